// File: rtl/prisel.sv
// Registered fixed-priority selector: grants the lowest-index requester and
// steers payload/response between the granted port and one shared resource.
module prisel #(
    parameter int unsigned NumPorts = 4,
    parameter type         T        = logic,
    parameter type         O        = logic
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [NumPorts-1:0] inb,
    output logic                valid,
    input  T                    ins [NumPorts],
    output T                    sel_i,
    output O                    outs [NumPorts],
    input  O                    sel_o
);

    logic [NumPorts-1:0] r_gnt;
    logic                r_valid;
    logic [NumPorts-1:0] w_pick;
    logic                w_found;
    T                    w_sel;

    // One-hot of the lowest set request bit, port 0 wins
    always_comb begin
        w_pick  = '0;
        w_found = 1'b0;
        for (int i = 0; i < int'(NumPorts); i++) begin
            if (inb[i] && !w_found) begin
                w_pick[i] = 1'b1;
                w_found   = 1'b1;
            end
        end
    end

    // Grant only moves while enable is high so the owner can keep the resource
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt   <= '0;
            r_valid <= 1'b0;
        end else if (enable) begin
            r_gnt   <= w_pick;
            r_valid <= |inb;
        end
    end

    always_comb begin
        w_sel = '0;
        for (int k = 0; k < int'(NumPorts); k++) begin
            if (r_gnt[k]) begin
                w_sel = ins[k];
            end
        end
    end

    // Response reaches only the granted slot; everyone else sees zero
    always_comb begin
        for (int j = 0; j < int'(NumPorts); j++) begin
            outs[j] = '0;
            if (r_gnt[j]) begin
                outs[j] = sel_o;
            end
        end
    end

    assign sel_i = w_sel;
    assign valid = r_valid;

endmodule

// File: tb/tb_prisel.sv
// Directed bench for prisel with a 3-bit struct payload and 2-bit response.
module tb_prisel;

    typedef struct packed {
        logic       a;
        logic [1:0] b;
    } req_t;

    typedef logic [1:0] rsp_t;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [3:0] inb;
    logic       valid;
    req_t       ins [4];
    req_t       sel_i;
    rsp_t       outs [4];
    rsp_t       sel_o;

    int n_checks;
    int n_fail;

    prisel #(
        .NumPorts (4),
        .T        (req_t),
        .O        (rsp_t)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .inb    (inb),
        .valid  (valid),
        .ins    (ins),
        .sel_i  (sel_i),
        .outs   (outs),
        .sel_o  (sel_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] outs_flat();
        return {outs[3], outs[2], outs[1], outs[0]};
    endfunction

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        enable   = 1'b1;
        inb      = 4'b1111;
        sel_o    = 2'b11;
        ins[0]   = req_t'(3'b000);
        ins[1]   = req_t'(3'b101);
        ins[2]   = req_t'(3'b010);
        ins[3]   = req_t'(3'b111);

        // Reset with everyone requesting
        tick();
        tick();
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_sel_i", 32'(sel_i), 32'd0);
        check("rst_outs",  32'(outs_flat()), 32'd0);

        // Port 0 beats port 3
        rst = 1'b0;
        inb = 4'b1001;
        tick();
        check("pri_valid", 32'(valid), 32'd1);
        check("pri_sel_i", 32'(sel_i), 32'b000);
        sel_o = 2'b10;
        #1;
        check("pri_outs", 32'(outs_flat()), 32'b00_00_00_10);

        // Re-arbitrate to port 1
        inb = 4'b0010;
        tick();
        check("rearb_valid", 32'(valid), 32'd1);
        check("rearb_sel_i", 32'(sel_i), 32'b101);
        sel_o = 2'b01;
        #1;
        check("rearb_outs", 32'(outs_flat()), 32'b00_00_01_00);

        // Grant port 3, then hold while port 0 requests
        inb = 4'b1000;
        tick();
        check("hold_grant", 32'(sel_i), 32'b111);
        enable = 1'b0;
        inb    = 4'b0001;
        for (int i = 1; i <= 3; i++) begin
            sel_o = rsp_t'(i);
            tick();
            check("hold_sel_i",  32'(sel_i), 32'b111);
            check("hold_valid",  32'(valid), 32'd1);
            check("hold_outs",   32'(outs_flat()), 32'({rsp_t'(i), 6'b0}));
        end
        enable = 1'b1;
        tick();
        check("release_sel_i", 32'(sel_i), 32'b000);
        check("release_outs",  32'(outs_flat()), 32'b00_00_00_11);

        // No request clears the grant
        inb = 4'b0000;
        tick();
        check("idle_valid", 32'(valid), 32'd0);
        check("idle_sel_i", 32'(sel_i), 32'd0);
        check("idle_outs",  32'(outs_flat()), 32'd0);

        // Hold with no request keeps valid low
        enable = 1'b0;
        inb    = 4'b0100;
        tick();
        check("idle_hold_valid", 32'(valid), 32'd0);

        // Same-cycle passthrough with port 2 granted
        enable = 1'b1;
        tick();
        check("pass_sel_i0", 32'(sel_i), 32'b010);
        ins[2] = req_t'(3'b110);
        #1;
        check("pass_sel_i1", 32'(sel_i), 32'b110);
        sel_o = 2'b10;
        #1;
        check("pass_outs", 32'(outs_flat()), 32'b00_10_00_00);

        // Reset while a grant is held beats enable=0
        rst    = 1'b1;
        enable = 1'b0;
        tick();
        check("rst_held_valid", 32'(valid), 32'd0);
        check("rst_held_sel_i", 32'(sel_i), 32'd0);
        check("rst_held_outs",  32'(outs_flat()), 32'd0);

        // Recovery after reset
        rst    = 1'b0;
        enable = 1'b1;
        inb    = 4'b0110;
        tick();
        check("recover_sel_i", 32'(sel_i), 32'b101);
        check("recover_outs",  32'(outs_flat()), 32'b00_00_10_00);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
